// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared definitions for the instruction fetch stage.
//   XLEN      - datapath / address width
//   NOP_INSTR - instruction word presented to decode out of reset (addi x0,x0,0)
//   state_t   - fetch FSM states
package if_stage_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,   // out of reset, no request driven
        REQ,    // presenting a fetch request at pc
        WAIT,   // request accepted, waiting for the response word
        HOLD    // instruction presented to decode until consumed
    } state_t;

endpackage

// File: rtl/if_stage_pc_next.sv
// pc_next: combinational next-PC selection for the fetch stage.
//   pc             - current fetch pc
//   advance        - a response was captured, step to the sequential pc
//   redirect_valid - branch/jump redirect strobe (highest priority)
//   redirect_pc    - redirect target; low two bits are dropped
//   pc_nxt         - selected next pc (redirect > pc+4 > hold)
import if_stage_pkg::*;

module pc_next (
    input  logic [XLEN-1:0] pc,
    input  logic            advance,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc_nxt
);

    always_comb begin
        pc_nxt = pc;
        if (redirect_valid)
            pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
        else if (advance)
            pc_nxt = pc + 32'd4;    // wraps naturally at 2^32
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: single-outstanding instruction fetch stage.
//   clk, rst                       - clock, async active-high reset
//   imem_req_valid/addr/ready      - fetch request to instruction memory
//   imem_rsp_valid/data            - response word from instruction memory
//   redirect_valid/pc              - branch/jump redirect
//   out_valid/ready/instr/pc       - fetched instruction handed to decode
import if_stage_pkg::*;

module if_stage #(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            kill, kill_nxt;
    logic            capture;

    pc_next u_pc_next (
        .pc             (pc),
        .advance        (capture),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_nxt         (pc_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            out_instr <= NOP_INSTR;
            out_pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            kill  <= kill_nxt;
            if (capture) begin
                out_instr <= imem_rsp_data;
                out_pc    <= pc;
            end
        end
    end

    // kill marks an accepted request whose response must be thrown away.
    // It can be set in REQ (redirect coinciding with accept) or in WAIT.
    // While set in REQ no new request is issued, so at most one request is
    // ever in flight and the discarded response cannot be confused with the
    // response to the redirected fetch.
    always_comb begin
        state_nxt      = state;
        kill_nxt       = kill;
        capture        = 1'b0;
        imem_req_valid = 1'b0;
        out_valid      = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = REQ;
            end
            REQ: begin
                imem_req_valid = !kill;
                if (kill) begin
                    if (imem_rsp_valid)
                        kill_nxt = 1'b0;
                end else if (imem_req_ready) begin
                    if (redirect_valid)
                        kill_nxt = 1'b1;    // stay in REQ at the new pc
                    else
                        state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    if (imem_rsp_valid) begin
                        kill_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        kill_nxt = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (kill) begin
                        kill_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                // A redirect or a handshake both end the hold; pc already
                // points past the held instruction or at the redirect target.
                if (redirect_valid || out_ready)
                    state_nxt = REQ;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign imem_req_addr = pc;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port imem_req_valid, output, 1 bit: a fetch request is presented.
REQ-005 SHALL have port imem_req_addr, output, 32 bits: the fetch address, word-aligned.
REQ-006 SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-007 SHALL have port imem_rsp_valid, input, 1 bit: the response word is valid.
REQ-008 SHALL have port imem_rsp_data, input, 32 bits: the fetched instruction word.
REQ-009 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect strobe.
REQ-010 SHALL have port redirect_pc, input, 32 bits: redirect target address.
REQ-011 SHALL have port out_valid, output, 1 bit: instr/pc are valid for decode (opcode extract, immediate generation).
REQ-012 SHALL have port out_ready, input, 1 bit: decode accepts the instruction.
REQ-013 SHALL have port out_instr, output, 32 bits: the held instruction word.
REQ-014 SHALL have port out_pc, output, 32 bits: the address of out_instr.

Function
REQ-015 SHALL implement the FSM states IDLE, REQ, WAIT and HOLD, with at most one outstanding memory request.
REQ-016 IDLE SHALL drive no request; it SHALL go to REQ on the first clock after reset deasserts.
REQ-017 REQ SHALL drive imem_req_valid=1 with imem_req_addr=pc, and SHALL go to WAIT on imem_req_ready=1.
REQ-018 Addr SHALL stay stable while valid && !ready, except when a redirect occurs (REQ-023).
REQ-019 WAIT SHALL, on imem_rsp_valid=1 with no kill pending, capture out_instr<=imem_rsp_data and out_pc<=pc, set pc<=pc+4, and go to HOLD.
REQ-020 HOLD SHALL drive out_valid=1 with stable out_instr/out_pc; on out_ready=1 it SHALL go to REQ.
REQ-021 out_valid SHALL be 1 only in HOLD; fetch-to-out latency SHALL be 1 cycle after the response (minimum 3 cycles from request accept: REQ, WAIT, HOLD).
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), with no flag raised.
REQ-023 In IDLE or REQ, redirect_valid SHALL set pc<=redirect_pc, and the FSM SHALL be in REQ next cycle; a request accepted in the same cycle SHALL be treated as killed (REQ-024).
REQ-024 In WAIT, redirect SHALL set pc<=redirect_pc and set kill; the next response SHALL be discarded, kill SHALL clear, and the FSM SHALL go to REQ.
REQ-025 Redirect in the same cycle as imem_rsp_valid in WAIT SHALL discard that response and go to REQ.
REQ-026 In HOLD, redirect SHALL drop out_valid the next cycle, set pc<=redirect_pc, and go to REQ; a simultaneous out_ready handshake SHALL still count as consumed.
REQ-027 redirect_pc[1:0] SHALL be forced to 2'b00; a later redirect SHALL override an earlier one.

Reset
REQ-028 On rst=1, asynchronously: state=IDLE, pc=RESET_PC, kill=0, out_instr=32'h0000_0013 (nop), out_pc=RESET_PC, imem_req_valid=0, out_valid=0.
REQ-029 Reset asserted mid-request SHALL drop all state; any late response after reset SHALL be ignored until a new request is accepted.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the NOP_INSTR constant 32'h0000_0013, and the XLEN=32 constant.
REQ-031 Next-PC selection (pc+4, redirect, hold) SHALL be the single sub-module pc_next, which is combinational; all registers SHALL stay in if_stage.

Verification
REQ-032 Reset, then ready=1, rsp one cycle later with data 32'h00500093 -> req addr 0x0; out_valid with instr 32'h00500093, pc 0x0; next req addr 0x4.
REQ-033 out_ready=0 for 5 cycles in HOLD -> out_valid, instr and pc stable; no new request until the handshake.
REQ-034 Redirect to 0x100 in WAIT, then rsp 32'hDEADBEEF -> response dropped, no out_valid, next req addr 0x100.
REQ-035 Redirect to 0x203 in HOLD with out_ready=0 -> out_valid=0 next cycle, next req addr 0x200.
REQ-036 PC at 0xFFFF_FFFC fetched and accepted -> next req addr 0x0000_0000.
REQ-037 rst asserted in WAIT, rsp arriving during reset -> outputs at reset values, first req addr RESET_PC, late rsp ignored.
